// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the shift command sequencer.
//   - 3-bit shifter op encodings (NOP, LOAD, LSL, LSR, ASR)
//   - SHAMT_MAX: largest shift the shifter can perform in one cycle
//   - FSM state encoding for the sequencer
//   - cmd_t: command record {op, amt, data} at the default amount width
//   - is_shift(): true for the three shift ops
package shift_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  localparam int SHAMT_MAX     = 3;
  localparam int AMT_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [2:0]               op;
    logic [AMT_W_DEFAULT-1:0] amt;
    logic [7:0]               data;
  } cmd_t;

  function automatic logic is_shift(input logic [2:0] op_code);
    return (op_code == OP_LSL) || (op_code == OP_LSR) || (op_code == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_cmd_seq_cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding queued shift commands.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   push, wdata     write request and word (ignored while full)
//   pop, rdata      read request (ignored while empty) and head word
//   full, empty     occupancy flags, derived from the registered count
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage array: data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= {AW{1'b0}};
      rptr  <= {AW{1'b0}};
      count <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: command sequencer in front of an 8-bit shifter register.
// Commands {op, amt, data} are queued in cmd_fifo, then executed one at a
// time: shifts are split into steps of at most SHAMT_MAX positions driven
// on op/shamt, LOAD drives d_in for one cycle, everything else is a single
// NOP cycle. The shifter register value (d_out) is then offered on res_*.
// Ports:
//   clk, reset                          clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_amt/cmd_data   command input
//   op, shamt, d_in                     controls to the shifter
//   d_out                               current shifter register value
//   res_valid/res_ready/res_data        result output
//   busy                                engine active or commands queued
// Optional build macro SEQ_CMD_CNT_EN adds cmd_cnt, a saturating count of
// completed result handshakes.
module shift_cmd_seq
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AMT_W = AMT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [7:0]       cmd_data,
  output logic [2:0]       op,
  output logic [1:0]       shamt,
  output logic [7:0]       d_in,
  input  logic [7:0]       d_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             busy
`ifdef SEQ_CMD_CNT_EN
  ,
  output logic [7:0]       cmd_cnt
`endif
);

  localparam int CW = 3 + AMT_W + 8;

  logic [CW-1:0]    fifo_wdata;
  logic [CW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  state_t           state;
  state_t           next_state;
  logic [2:0]       w_op;
  logic [2:0]       next_op;
  logic [AMT_W-1:0] w_rem;
  logic [AMT_W-1:0] next_rem;
  logic [7:0]       w_data;
  logic [7:0]       next_data;
  logic [AMT_W-1:0] step;
  logic [AMT_W-1:0] rem_after;

  assign fifo_wdata = {cmd_op, cmd_amt, cmd_data};
  assign cmd_ready  = !fifo_full;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Per-cycle step: clamp the remaining amount to what the shifter can do.
  always_comb begin
    step = w_rem;
    if (w_rem > AMT_W'(SHAMT_MAX)) begin
      step = AMT_W'(SHAMT_MAX);
    end else begin
      step = w_rem;
    end
    rem_after = w_rem - step;
  end

  // State register and working copy of the command being executed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      w_op   <= OP_NOP;
      w_rem  <= {AMT_W{1'b0}};
      w_data <= 8'h00;
    end else begin
      state  <= next_state;
      w_op   <= next_op;
      w_rem  <= next_rem;
      w_data <= next_data;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    next_state = state;
    next_op    = w_op;
    next_rem   = w_rem;
    next_data  = w_data;
    fifo_pop   = 1'b0;
    op         = OP_NOP;
    shamt      = 2'b00;
    d_in       = 8'h00;
    res_valid  = 1'b0;
    res_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_op    = fifo_rdata[CW-1 -: 3];
          next_rem   = fifo_rdata[8 +: AMT_W];
          next_data  = fifo_rdata[7:0];
          next_state = ST_EXEC;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (is_shift(w_op) && (w_rem != {AMT_W{1'b0}})) begin
          op       = w_op;
          shamt    = step[1:0];
          next_rem = rem_after;
          // w_rem only ever decreases by at most its own value, so it
          // reaches zero exactly on the last step and never wraps.
          if (rem_after == {AMT_W{1'b0}}) begin
            next_state = ST_RESP;
          end else begin
            next_state = ST_EXEC;
          end
        end else if (w_op == OP_LOAD) begin
          op         = OP_LOAD;
          d_in       = w_data;
          next_state = ST_RESP;
        end else begin
          // NOP, illegal op or zero-length shift: one idle cycle.
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        res_valid = 1'b1;
        res_data  = d_out;
        if (res_ready) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_RESP;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

`ifdef SEQ_CMD_CNT_EN
  // Saturating count of completed result handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_cnt <= 8'h00;
    end else if ((state == ST_RESP) && res_ready && (cmd_cnt != 8'hFF)) begin
      cmd_cnt <= cmd_cnt + 8'h01;
    end else begin
      cmd_cnt <= cmd_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb_shift_cmd_seq: scoreboard bench for shift_cmd_seq.
// A behavioural shifter register closes the loop (op/shamt/d_in -> d_out).
// The reference model applies each accepted command as a whole shift of
// `amt` positions on an 8-bit value and predicts the result, the op seen
// on the shifter bus, the number of active cycles and the total shift.
// A monitor on the falling edge pops and compares.
module tb_shift_cmd_seq;
  import shift_pkg::*;

  localparam int DEPTH = 4;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b000;
  logic [AMT_W-1:0] cmd_amt = '0;
  logic [7:0]       cmd_data = 8'h00;
  logic [2:0]       op;
  logic [1:0]       shamt;
  logic [7:0]       d_in;
  logic [7:0]       d_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [7:0]       res_data;
  logic             busy;
`ifdef SEQ_CMD_CNT_EN
  logic [7:0]       cmd_cnt;
`endif

  shift_cmd_seq #(.DEPTH(DEPTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .op        (op),
    .shamt     (shamt),
    .d_in      (d_in),
    .d_out     (d_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
`ifdef SEQ_CMD_CNT_EN
    ,
    .cmd_cnt   (cmd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural shifter register driven by the sequencer.
  logic [7:0] sh_reg;
  assign d_out = sh_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh_reg <= 8'h00;
    else begin
      case (op)
        OP_LOAD: sh_reg <= d_in;
        OP_LSL:  sh_reg <= sh_reg << shamt;
        OP_LSR:  sh_reg <= sh_reg >> shamt;
        OP_ASR:  sh_reg <= 8'($signed(sh_reg) >>> shamt);
        default: sh_reg <= sh_reg;
      endcase
    end
  end

  typedef struct {
    logic [7:0] res;
    logic [2:0] op;
    logic [7:0] data;
    int         steps;
    int         sum;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model_val = 8'h00;
  int         compared = 0;
  int         mismatched = 0;
  int         act_cnt = 0;
  int         act_sum = 0;
  int         hs_cnt = 0;
  int         rr_mode = 0;  // 0: hold low, 1: hold high, 2: random

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    compared++;
    mismatched++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Reference model: whole-command semantics, applied in acceptance order.
  function automatic void push_exp(logic [2:0] o, logic [AMT_W-1:0] a, logic [7:0] d);
    exp_t e;
    int   amt;
    amt     = int'(a);
    e.op    = o;
    e.data  = d;
    e.steps = 0;
    e.sum   = 0;
    case (o)
      3'b001: begin model_val = d; e.steps = 1; end
      3'b010: model_val = model_val << amt;
      3'b011: model_val = model_val >> amt;
      3'b100: model_val = 8'($signed(model_val) >>> amt);
      default: ;
    endcase
    if ((o == 3'b010 || o == 3'b011 || o == 3'b100) && amt > 0) begin
      e.steps = (amt + 2) / 3;
      e.sum   = amt;
    end
    e.res = model_val;
    q.push_back(e);
  endfunction

  // res_ready driver, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares shifter-bus activity and results against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (op != OP_NOP) begin
          if (q.size() == 0) fail_now("op_without_cmd");
          else begin
            chk("exec_op", 32'(op), 32'(q[0].op));
            if (op == OP_LOAD) chk("load_d_in", 32'(d_in), 32'(q[0].data));
            act_cnt++;
            if (op != OP_LOAD) act_sum += int'(shamt);
          end
        end
        if (res_valid) begin
          if (q.size() == 0) fail_now("res_without_cmd");
          else begin
            chk("res_data", 32'(res_data), 32'(q[0].res));
            if (res_ready) begin
              chk("step_count", 32'(act_cnt), 32'(q[0].steps));
              chk("step_sum", 32'(act_sum), 32'(q[0].sum));
              void'(q.pop_front());
              act_cnt = 0;
              act_sum = 0;
              hs_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [AMT_W-1:0] a, input logic [7:0] d);
    bit done = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = o;
    cmd_amt   = a;
    cmd_data  = d;
    for (int i = 0; i < 400 && !done; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        push_exp(o, a, d);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) fail_now("cmd_accept_timeout");
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) done = 1;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_op"}, 32'(op), 32'(OP_NOP));
    chk({tag, "_shamt"}, 32'(shamt), 32'd0);
    chk({tag, "_d_in"}, 32'(d_in), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lsl_seen;
    int r;
    logic [2:0] o;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    rr_mode = 1;

    // Directed scenarios with res_ready held high.
    send(OP_LOAD, 3'd0, 8'h96);
    send(OP_ASR, 3'd5, 8'h00);
    send(OP_LOAD, 3'd0, 8'h01);
    send(OP_LSL, 3'd7, 8'h00);
    send(OP_LOAD, 3'd0, 8'hA5);
    send(OP_LSR, 3'd0, 8'h00);
    send(3'b111, 3'd4, 8'h3C);
    send(OP_NOP, 3'd2, 8'h11);
    wait_idle();

    // Back-pressure: one command is taken by the engine, DEPTH more fill the FIFO.
    rr_mode = 0;
    @(posedge clk); #2;
    send(OP_LOAD, 3'd0, 8'hC3);
    send(OP_LSR, 3'd3, 8'h00);
    send(OP_ASR, 3'd2, 8'h00);
    send(OP_LSL, 3'd1, 8'h00);
    send(OP_LSR, 3'd7, 8'h00);
    @(negedge clk);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("still_full", 32'(cmd_ready), 32'd0);
    chk("held_res_valid", 32'(res_valid), 32'd1);
    rr_mode = 1;
    send(OP_LOAD, 3'd0, 8'h7E);
    wait_idle();

    // Reset during the second step of LSL 7.
    send(OP_LOAD, 3'd0, 8'h01);
    send(OP_LSL, 3'd7, 8'h00);
    lsl_seen = 0;
    for (int i = 0; i < 40 && lsl_seen < 2; i++) begin
      @(negedge clk);
      if (op == OP_LSL) lsl_seen++;
    end
    if (lsl_seen < 2) fail_now("lsl_step_not_seen");
    #2 reset = 1'b1;
    #1;
    check_reset_state("midcmd_reset");
    q.delete();
    model_val = 8'h00;
    act_cnt = 0;
    act_sum = 0;
    hs_cnt = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    send(OP_LOAD, 3'd0, 8'h5A);
    send(OP_LSR, 3'd3, 8'h00);
    wait_idle();

    // Randomized traffic with random res_ready.
    rr_mode = 2;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    o = OP_LOAD;
        2, 3:    o = OP_LSL;
        4, 5:    o = OP_LSR;
        6, 7:    o = OP_ASR;
        8:       o = OP_NOP;
        default: o = 3'($urandom_range(5, 7));
      endcase
      send(o, AMT_W'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    rr_mode = 1;
    wait_idle();
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_queue_empty", 32'(q.size()), 32'd0);
`ifdef SEQ_CMD_CNT_EN
    chk("cmd_cnt", 32'(cmd_cnt), 32'(hs_cnt > 255 ? 255 : hs_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
